escritor_framebuffer: RTL



---
 rtl/escritor_framebuffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/escritor_framebuffer.sv
// ---------------------------------------------------------------------------
// escritor_framebuffer
//
// Framebuffer write engine for the VGA path. A start pulse captures one packed
// word and a base address. The engine then writes the word's pixels, one per
// cycle, to consecutive framebuffer RAM addresses. The address wraps from
// MEM_DEPTH-1 back to 0. A one-cycle done pulse marks the end of a transfer.
//
// Parameters:
//   DATA_W    width of the packed input word (a multiple of PIXEL_W)
//   PIXEL_W   bits per pixel written to RAM
//   ADDR_W    framebuffer address width
//   MEM_DEPTH number of RAM words (2 .. 2**ADDR_W)
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   start          request to write one word (sampled only while idle)
//   dados_in       packed pixels, pixel 0 in the least significant bits
//   endereco_base  RAM address of pixel 0
//   data           pixel value to RAM
//   wraddress      RAM write address
//   wren           RAM write enable (data/wraddress valid only when high)
//   busy           high while writing and during the done cycle
//   done           one-cycle completion pulse
//
// Optional feature (macro TRANSPARENT_SKIP_EN):
//   When the macro is defined, all-zero pixels are treated as transparent.
//   For such a pixel, wren stays low, but the address and pixel counters still
//   advance, so transfer timing does not change.
// ---------------------------------------------------------------------------
module escritor_framebuffer #(
    parameter int DATA_W    = 32,
    parameter int PIXEL_W   = 1,
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  dados_in,
    input  logic [ADDR_W-1:0]  endereco_base,
    output logic [PIXEL_W-1:0] data,
    output logic [ADDR_W-1:0]  wraddress,
    output logic               wren,
    output logic               busy,
    output logic               done
);

    localparam int                NPIX      = DATA_W / PIXEL_W;
    localparam int                CNT_W     = $clog2(NPIX) + 1;
    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [ADDR_W-1:0]  addr_cnt, addr_next;
    logic [CNT_W-1:0]   pix_cnt, pix_next;
    logic [PIXEL_W-1:0] data_next;
    logic [ADDR_W-1:0]  wraddress_next;
    logic               wren_next, busy_next, done_next;

    logic               emit;
    logic               emit_visible;
    logic [PIXEL_W-1:0] emit_pixel;
    logic [ADDR_W-1:0]  emit_addr;

    // Compute the next address, wrapping at the end of the framebuffer.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    // Next-state logic. All outputs are registered, so this block computes
    // the value every output takes after the next edge. Pixel 0 is issued on
    // the same edge that accepts start, so it appears one cycle after start.
    // addr_cnt tracks the address of the pixel being presented. It is kept
    // separate from wraddress because wraddress holds its value while a
    // transparent pixel is skipped.
    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        addr_next      = addr_cnt;
        pix_next       = pix_cnt;
        data_next      = data;
        wraddress_next = wraddress;
        wren_next      = 1'b0;
        busy_next      = busy;
        done_next      = 1'b0;
        emit           = 1'b0;
        emit_visible   = 1'b0;
        emit_pixel     = '0;
        emit_addr      = '0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    state_next = WRITE;
                    busy_next  = 1'b1;
                    pix_next   = '0;
                    emit       = 1'b1;
                    emit_pixel = dados_in[PIXEL_W-1:0];
                    emit_addr  = endereco_base;
                    shift_next = dados_in >> PIXEL_W;
                end
            end
            WRITE: begin
                if (pix_cnt == LAST_PIX) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    pix_next   = pix_cnt + CNT_W'(1);
                    emit       = 1'b1;
                    emit_pixel = shift_reg[PIXEL_W-1:0];
                    emit_addr  = wrap_inc(addr_cnt);
                    shift_next = shift_reg >> PIXEL_W;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

`ifdef TRANSPARENT_SKIP_EN
        emit_visible = (emit_pixel != '0);
`else
        emit_visible = 1'b1;
`endif

        // The address always advances. data and wraddress update only on a
        // real write, so they hold their last values whenever wren is low.
        if (emit) begin
            addr_next = emit_addr;
            if (emit_visible) begin
                wren_next      = 1'b1;
                data_next      = emit_pixel;
                wraddress_next = emit_addr;
            end
        end
    end

    // State and output registers. Reset aborts any transfer in progress
    // without pulsing done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            addr_cnt  <= '0;
            pix_cnt   <= '0;
            data      <= '0;
            wraddress <= '0;
            wren      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            addr_cnt  <= addr_next;
            pix_cnt   <= pix_next;
            data      <= data_next;
            wraddress <= wraddress_next;
            wren      <= wren_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule
